// File: rtl/game_pkg.sv
// Shared game constants: FSM encodings, LFSR seed/taps and the LFSR step function.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      STOP = 2'b11
   } game_state_t;

   // Fibonacci taps for x^8+x^6+x^5+x^4+1: bits 7,5,4,3 of a left-shifting register.
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // One LFSR step. Bit 7 is part of the feedback, so the map is invertible and a
   // nonzero state can never become zero.
   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit maximal-length LFSR used as the gap-height random source.
// Latency: advances once per clock in every state; q is the registered value.
// Backpressure: none, free-running.
module lfsr8
   import game_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   output logic [7:0] q
);

   // Shift every clock; reload the seed on reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         q <= LFSR_SEED;
      end else begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/wall_scroll_ctrl.sv
// Scrolls NUM_WALLS walls leftwards per frame tick, wraps them with a new random gap, and scores wraps.
// Latency: positions/respawn/score update one cycle after the tick; running/stopped decode the state register.
// Backpressure: none; touched pre-empts a simultaneous frame_tick, STOP ignores ticks.
module wall_scroll_ctrl
   import game_pkg::*;
#(
   parameter int NUM_WALLS = 3,
   parameter int X_W       = 9,
   parameter int SCREEN_W  = 160,
   parameter int SPACING   = 64,
   parameter int GAP_MIN   = 16
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     start,
   input  logic                     touched,
   input  logic                     frame_tick,
   input  logic [2:0]               speed,
   output logic [NUM_WALLS*X_W-1:0] wall_x,
   output logic [NUM_WALLS*7-1:0]   gap_y,
   output logic [NUM_WALLS-1:0]     respawn,
   output logic [7:0]               score,
   output logic                     running,
   output logic                     stopped
);

   // Distance added on a wrap: the full ring of walls.
   localparam logic [X_W-1:0] WRAP_DIST = X_W'(NUM_WALLS * SPACING);

   // Elaboration-time sanity checks on the geometry.
   if (X_W < $clog2(SCREEN_W + NUM_WALLS * SPACING)) begin : g_xw_check
      $error("wall_scroll_ctrl: X_W too narrow for SCREEN_W + NUM_WALLS*SPACING");
   end
   if (SPACING < 8 || SPACING > 255) begin : g_spacing_check
      $error("wall_scroll_ctrl: SPACING must be in 8..255");
   end

   game_state_t          state;
   game_state_t          state_nxt;
   logic [7:0]           lfsr_q;
   logic [2:0]           s_eff;
   logic                 step;
   logic [NUM_WALLS-1:0] wrap_vec;
   logic                 lfsr_unused;

   lfsr8 u_lfsr (
      .clk    (clk),
      .resetn (resetn),
      .q      (lfsr_q)
   );

   // Only the low six LFSR bits feed the gap height.
   assign lfsr_unused = ^lfsr_q[7:6];

   // A zero speed would freeze the game, so it is promoted to one pixel per tick.
   assign s_eff = (speed == 3'd0) ? 3'd1 : speed;

   // Movement happens only on an uncontested tick while running.
   assign step = (state == RUN) && frame_tick && !touched;

   assign running = (state == RUN);
   assign stopped = (state == STOP);

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; illegal encodings fall back to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)   state_nxt = RUN;
         RUN:     if (touched) state_nxt = STOP;
         STOP:    if (start)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Per-wall position, gap and respawn pulse.
   for (genvar i = 0; i < NUM_WALLS; i++) begin : g_wall
      localparam logic [X_W-1:0] X_INIT   = X_W'(SCREEN_W + i * SPACING);
      localparam logic [6:0]     GAP_INIT = 7'(GAP_MIN + 16 * i);

      logic [X_W-1:0] x_q;
      logic [6:0]     gap_q;
      logic           rsp_q;

      assign wrap_vec[i] = (x_q < X_W'(s_eff));

      // IDLE keeps reloading the start layout; RUN ticks move or wrap the wall.
      always_ff @(posedge clk) begin
         if (!resetn || state == IDLE) begin
            x_q   <= X_INIT;
            gap_q <= GAP_INIT;
            rsp_q <= 1'b0;
         end else if (step) begin
            rsp_q <= wrap_vec[i];
            if (wrap_vec[i]) begin
               x_q   <= x_q + WRAP_DIST - X_W'(s_eff);
               gap_q <= 7'(GAP_MIN) + {1'b0, lfsr_q[5:0]};
            end else begin
               x_q   <= x_q - X_W'(s_eff);
            end
         end else begin
            rsp_q <= 1'b0;
         end
      end

      assign wall_x[i*X_W +: X_W] = x_q;
      assign gap_y[i*7 +: 7]      = gap_q;
      assign respawn[i]           = rsp_q;
   end

   // Score counts wrapping ticks (at most one wrap per tick) and saturates.
   always_ff @(posedge clk) begin
      if (!resetn || state == IDLE) begin
         score <= 8'd0;
      end else if (step && (|wrap_vec) && (score != 8'hFF)) begin
         score <= score + 8'd1;
      end
   end

endmodule

// File: doc/wall_scroll_ctrl.md
WALL_SCROLL_CTRL -- requirements
Module: wall_scroll_ctrl

Interface
REQ-001 The block SHALL take parameter NUM_WALLS, default 3: number of independent wall channels.
REQ-002 The block SHALL take parameter X_W, default 9: width of each wall x-position.
REQ-003 The block SHALL take parameter SCREEN_W, default 160: x of the first wall after init.
REQ-004 The block SHALL take parameter SPACING, default 64: x distance between consecutive walls, legal range 8 to 255.
REQ-005 The block SHALL take parameter GAP_MIN, default 16: lowest gap y.
REQ-006 Port clk: input, 1 bit, clock; reset resetn, synchronous, active-low; clock clk.
REQ-007 Port resetn: input, 1 bit, synchronous active-low reset.
REQ-008 Port start: input, 1 bit, level; starts a run from IDLE, or clears a finished run from STOP.
REQ-009 Port touched: input, 1 bit, collision reported by the player logic.
REQ-010 Port frame_tick: input, 1 bit, one-cycle pulse per frame.
REQ-011 Port speed: input, 3 bits, pixels moved per tick; value 0 is treated as 1.
REQ-012 Port wall_x: output, NUM_WALLS*X_W bits, packed x positions; wall i occupies bits [i*X_W +: X_W].
REQ-013 Port gap_y: output, NUM_WALLS*7 bits, packed gap y per wall.
REQ-014 Port respawn: output, NUM_WALLS bits, one-cycle pulse per wall on wrap.
REQ-015 Port score: output, 8 bits, count of walls passed.
REQ-016 Port running and stopped: outputs, 1 bit each, state flags.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and STOP.
REQ-018 The FSM SHALL move IDLE->RUN when start=1, RUN->STOP when touched=1, and STOP->IDLE when start=1; every other case holds state; an undefined encoding SHALL go to IDLE.
REQ-019 In IDLE, the block SHALL load wall i with x=SCREEN_W+i*SPACING and gap_y=GAP_MIN+16*i, SHALL clear score, and SHALL drive respawn=0.
REQ-020 In RUN, on each frame_tick with touched=0, every wall SHALL update in the next cycle: if x>=s then x<=x-s, otherwise x<=x+NUM_WALLS*SPACING-s; s is the effective speed.
REQ-021 On a wrap, the block SHALL pulse respawn[i] for exactly one cycle, with the new x.
REQ-022 On a wrap, the block SHALL load gap_y[i]=GAP_MIN+lfsr[5:0], using the LFSR value in the tick cycle.
REQ-023 On a wrap, score SHALL increment by 1 and saturate at 255.
REQ-024 The SPACING>=8 constraint SHALL guarantee at most one wrap per tick.
REQ-025 touched SHALL take priority over a simultaneous frame_tick: no movement, no respawn and no score change occur in that cycle.
REQ-026 In STOP, x, gap_y and score SHALL be frozen, and frame_tick SHALL be ignored.
REQ-027 The 8-bit LFSR SHALL use polynomial x^8+x^6+x^5+x^4+1, SHALL advance every clock in all states, SHALL have seed 8'hA5, and SHALL never reach 0.
REQ-028 running SHALL equal (state==RUN), and stopped SHALL equal (state==STOP); both are registered-state decodes with zero latency.
REQ-029 X_W SHALL be at least clog2(SCREEN_W+NUM_WALLS*SPACING); this SHALL be checked at elaboration.

Reset
REQ-030 When resetn=0 at a clk edge, the next state SHALL be: state=IDLE, x and gap_y at their REQ-019 values, score=0, respawn=0, lfsr=8'hA5, running=0, stopped=0.
REQ-031 Reset asserted in RUN or STOP SHALL abort immediately, with no respawn pulse.

Structure
REQ-032 The state encodings (IDLE=2'b00, RUN=2'b01, STOP=2'b11), the LFSR seed and the taps SHALL be placed in the shared package game_pkg.
REQ-033 The LFSR SHALL be a sub-module named lfsr8, with ports clk, resetn and q[7:0].
REQ-034 The per-wall update SHALL be a generate loop over NUM_WALLS.

Verification (defaults NUM_WALLS=3, SCREEN_W=160, SPACING=64)
REQ-035 Reset then start=1 -> next cycle: running=1, x={160,224,288}, score=0.
REQ-036 RUN, speed=3, wall0 x=2, one tick -> wall0 x=191, respawn=3'b001 for one cycle, score=1, gap_y[0] in [16,79].
REQ-037 RUN, touched=1 in the same cycle as frame_tick -> stopped=1, all x unchanged, respawn=0.
REQ-038 STOP, 10 ticks, then start=1 -> values frozen during STOP; IDLE follows, re-initialising x={160,224,288} and score=0.
REQ-039 Score at 255 plus one more wrap -> score stays 255, and respawn still pulses.
REQ-040 speed=0, RUN, 5 ticks -> each x decreases by exactly 5.
